// File: rtl/scg_mrs_seq.sv
// Mode-register command sequencer: optional PALL + N_REF x AREF, then MRS, with tRP/tRFC/tMRD NOP gaps.
// Outputs are registered from the next state, so command/addr/busy/done line up with the state they belong to.
module scg_mrs_seq #(
  parameter int ADDR_W = 12,
  parameter int T_RP   = 3,
  parameter int T_RFC  = 7,
  parameter int T_MRD  = 2,
  parameter int N_REF  = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              full_seq,
  input  logic [2:0]        burst_len,
  input  logic              burst_type,
  input  logic [2:0]        cas_lat,
  input  logic              wr_single,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [3:0]        command,
  output logic [ADDR_W-1:0] addr
);

  localparam int T_MAX = (T_RP > T_RFC) ? ((T_RP > T_MRD) ? T_RP : T_MRD)
                                        : ((T_RFC > T_MRD) ? T_RFC : T_MRD);
  localparam int WC_W  = $clog2(T_MAX + 1);
  localparam int RC_W  = (N_REF > 0) ? $clog2(N_REF + 1) : 1;

  localparam logic [WC_W-1:0]   LD_RP  = WC_W'(T_RP - 1);
  localparam logic [WC_W-1:0]   LD_RFC = WC_W'(T_RFC - 1);
  localparam logic [WC_W-1:0]   LD_MRD = WC_W'(T_MRD - 1);
  localparam logic [RC_W-1:0]   LD_REF = RC_W'(N_REF);
  localparam logic [ADDR_W-1:0] ADDR_PALL = ADDR_W'(1) << 10;

  localparam logic [3:0] CMD_NOP  = 4'd0;
  localparam logic [3:0] CMD_PALL = 4'd2;
  localparam logic [3:0] CMD_AREF = 4'd4;
  localparam logic [3:0] CMD_MRS  = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE, S_PALL, S_WAIT_RP, S_AREF, S_WAIT_RFC, S_MRS, S_WAIT_MRD, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [WC_W-1:0]   wait_cnt;
  logic [RC_W-1:0]   ref_cnt;
  logic [ADDR_W-1:0] mode_q;
  logic              err_q;

  logic              bl_bad, cl_bad;
  logic [2:0]        bl_use, cl_use;
  logic [ADDR_W-1:0] mode_in;
  logic [3:0]        cmd_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  state_t            after_rp;

  // Reserved BL codes and unsupported CAS latencies fall back to BL8 / CL3.
  always_comb begin
    bl_bad  = (burst_len == 3'b100) || (burst_len == 3'b101) || (burst_len == 3'b110);
    cl_bad  = !((cas_lat == 3'b010) || (cas_lat == 3'b011));
    bl_use  = bl_bad ? 3'b011 : burst_len;
    cl_use  = cl_bad ? 3'b011 : cas_lat;
    mode_in = '0;
    mode_in[2:0] = bl_use;
    mode_in[3]   = burst_type;
    mode_in[6:4] = cl_use;
    mode_in[9]   = wr_single;
  end

  always_comb begin
    state_nxt = state;
    after_rp  = (N_REF > 0) ? S_AREF : S_MRS;
    unique case (state)
      S_IDLE:     if (start) state_nxt = full_seq ? S_PALL : S_MRS;
      S_PALL:     state_nxt = (T_RP > 1) ? S_WAIT_RP : after_rp;
      S_WAIT_RP:  if (wait_cnt == WC_W'(1)) state_nxt = after_rp;
      // ref_cnt still counts the refresh being issued in this cycle.
      S_AREF: begin
        if (T_RFC > 1)                state_nxt = S_WAIT_RFC;
        else if (ref_cnt > RC_W'(1))  state_nxt = S_AREF;
        else                          state_nxt = S_MRS;
      end
      S_WAIT_RFC: if (wait_cnt == WC_W'(1)) state_nxt = (ref_cnt != '0) ? S_AREF : S_MRS;
      S_MRS:      state_nxt = (T_MRD > 1) ? S_WAIT_MRD : S_DONE;
      S_WAIT_MRD: if (wait_cnt == WC_W'(1)) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_nxt  = CMD_NOP;
    addr_nxt = '0;
    unique case (state_nxt)
      S_PALL: begin
        cmd_nxt  = CMD_PALL;
        addr_nxt = ADDR_PALL;
      end
      S_AREF: cmd_nxt = CMD_AREF;
      S_MRS: begin
        cmd_nxt  = CMD_MRS;
        addr_nxt = (state == S_IDLE) ? mode_in : mode_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      ref_cnt  <= '0;
      mode_q   <= '0;
      err_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      command  <= CMD_NOP;
      addr     <= '0;
    end else begin
      state <= state_nxt;

      if (state == S_IDLE && start) begin
        mode_q <= mode_in;
        err_q  <= bl_bad | cl_bad;
      end

      if (state_nxt == S_WAIT_RP && state != S_WAIT_RP)
        wait_cnt <= LD_RP;
      else if (state_nxt == S_WAIT_RFC && state != S_WAIT_RFC)
        wait_cnt <= LD_RFC;
      else if (state_nxt == S_WAIT_MRD && state != S_WAIT_MRD)
        wait_cnt <= LD_MRD;
      else if (wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;

      if (state_nxt == S_PALL)
        ref_cnt <= LD_REF;
      else if (state == S_AREF && ref_cnt != '0)
        ref_cnt <= ref_cnt - 1'b1;

      busy    <= (state_nxt != S_IDLE);
      done    <= (state_nxt == S_DONE);
      cfg_err <= (state_nxt == S_DONE) ? err_q : 1'b0;
      command <= cmd_nxt;
      addr    <= addr_nxt;
    end
  end

endmodule

// File: tb/tb_scg_mrs_seq.sv
// Bench for scg_mrs_seq: directed vector table, reset corner cases and randomized sequences
// checked cycle by cycle against an expected command trace built from the sequencing rules.
module tb_scg_mrs_seq;

  localparam int ADDR_W = 12;
  localparam int T_RP   = 3;
  localparam int T_RFC  = 7;
  localparam int T_MRD  = 2;
  localparam int N_REF  = 2;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              start;
  logic              full_seq;
  logic [2:0]        burst_len;
  logic              burst_type;
  logic [2:0]        cas_lat;
  logic              wr_single;
  logic              busy, done, cfg_err;
  logic [3:0]        command;
  logic [ADDR_W-1:0] addr;

  int n_tests = 0;
  int n_fail  = 0;

  scg_mrs_seq #(
    .ADDR_W(ADDR_W), .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD), .N_REF(N_REF)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .full_seq(full_seq),
    .burst_len(burst_len), .burst_type(burst_type), .cas_lat(cas_lat),
    .wr_single(wr_single), .busy(busy), .done(done), .cfg_err(cfg_err),
    .command(command), .addr(addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [11:0] adr;
    logic        dn;
    logic        er;
  } exp_t;

  typedef struct {
    logic        f;
    logic [2:0]  bl;
    logic        bt;
    logic [2:0]  cl;
    logic        ws;
    int          poke;
    logic [11:0] ea;
    logic        ee;
    int          el;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Mode word straight from the field table: legal BL codes 0,1,2,3,7; legal CL 2,3.
  function automatic logic [11:0] mode_word(input logic [2:0] bl, input logic bt,
                                            input logic [2:0] cl, input logic ws,
                                            output logic err);
    int blv, clv;
    logic bl_ok, cl_ok;
    bl_ok = (bl <= 3) || (bl == 7);
    cl_ok = (cl == 2) || (cl == 3);
    blv = bl_ok ? int'(bl) : 3;
    clv = cl_ok ? int'(cl) : 3;
    err = !(bl_ok && cl_ok);
    return 12'(blv + 8 * int'(bt) + 16 * clv + 512 * int'(ws));
  endfunction

  task automatic randomize_inputs();
    full_seq   = 1'($urandom);
    burst_len  = 3'($urandom);
    burst_type = 1'($urandom);
    cas_lat    = 3'($urandom);
    wr_single  = 1'($urandom);
  endtask

  // Caller is at a negedge in an IDLE cycle. poke = i means start is pulsed
  // (with junk config) in the cycle after trace sample i; it must be ignored.
  task automatic run_seq(input logic f, input logic [2:0] bl, input logic bt,
                         input logic [2:0] cl, input logic ws, input int poke,
                         output logic [11:0] g_addr, output logic g_err, output int g_lat);
    exp_t q[$];
    exp_t e;
    logic [11:0] w;
    logic werr;
    w = mode_word(bl, bt, cl, ws, werr);
    if (f) begin
      q.push_back('{cmd: 4'd2, adr: 12'h400, dn: 1'b0, er: 1'b0});
      repeat (T_RP - 1) q.push_back('{cmd: 4'd0, adr: 12'h000, dn: 1'b0, er: 1'b0});
      repeat (N_REF) begin
        q.push_back('{cmd: 4'd4, adr: 12'h000, dn: 1'b0, er: 1'b0});
        repeat (T_RFC - 1) q.push_back('{cmd: 4'd0, adr: 12'h000, dn: 1'b0, er: 1'b0});
      end
    end
    q.push_back('{cmd: 4'd8, adr: w, dn: 1'b0, er: 1'b0});
    repeat (T_MRD - 1) q.push_back('{cmd: 4'd0, adr: 12'h000, dn: 1'b0, er: 1'b0});
    q.push_back('{cmd: 4'd0, adr: 12'h000, dn: 1'b1, er: werr});

    g_addr = 12'hxxx;
    g_err  = 1'bx;
    g_lat  = 0;
    full_seq = f; burst_len = bl; burst_type = bt; cas_lat = cl; wr_single = ws;
    start = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      e = q[i];
      chk($sformatf("trace[%0d]", i + 1),
          32'({busy, done, cfg_err, command, addr}),
          32'({1'b1, e.dn, e.er, e.cmd, e.adr}));
      if (e.cmd == 4'd8) g_addr = addr;
      if (e.dn) g_err = cfg_err;
      if (done && g_lat == 0) g_lat = i + 1;
      randomize_inputs();
      start = (i == poke);
    end
    @(negedge clk);
    start = 1'b0;
    chk("idle_after", 32'({busy, done, cfg_err, command, addr}), 32'h0);
  endtask

  vec_t        tbl[8];
  logic [11:0] g_addr;
  logic        g_err;
  int          g_lat;
  logic        found;

  initial begin
    tbl[0] = '{f: 0, bl: 3'b011, bt: 0, cl: 3'b010, ws: 0, poke: -1, ea: 12'h023, ee: 0, el: 3};
    tbl[1] = '{f: 1, bl: 3'b011, bt: 0, cl: 3'b010, ws: 0, poke: 5,  ea: 12'h023, ee: 0, el: 20};
    tbl[2] = '{f: 0, bl: 3'b101, bt: 0, cl: 3'b111, ws: 0, poke: -1, ea: 12'h033, ee: 1, el: 3};
    tbl[3] = '{f: 1, bl: 3'b111, bt: 1, cl: 3'b011, ws: 1, poke: 19, ea: 12'h23F, ee: 0, el: 20};
    tbl[4] = '{f: 0, bl: 3'b100, bt: 0, cl: 3'b000, ws: 0, poke: 1,  ea: 12'h033, ee: 1, el: 3};
    tbl[5] = '{f: 0, bl: 3'b110, bt: 1, cl: 3'b010, ws: 1, poke: 2,  ea: 12'h22B, ee: 1, el: 3};
    tbl[6] = '{f: 1, bl: 3'b000, bt: 0, cl: 3'b011, ws: 0, poke: 12, ea: 12'h030, ee: 0, el: 20};
    tbl[7] = '{f: 0, bl: 3'b010, bt: 0, cl: 3'b001, ws: 0, poke: -1, ea: 12'h032, ee: 1, el: 3};

    // Reset held with start asserted: everything stays quiet.
    n_rst = 1'b0;
    start = 1'b1;
    randomize_inputs();
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({busy, done, cfg_err, command, addr}), 32'h0);
    start = 1'b0;
    n_rst = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 32'({busy, done, cfg_err, command, addr}), 32'h0);

    // Directed vectors, issued back to back so each start lands in the first IDLE cycle.
    foreach (tbl[k]) begin
      run_seq(tbl[k].f, tbl[k].bl, tbl[k].bt, tbl[k].cl, tbl[k].ws, tbl[k].poke,
              g_addr, g_err, g_lat);
      chk($sformatf("vec%0d_mrs_addr", k), 32'(g_addr), 32'(tbl[k].ea));
      chk($sformatf("vec%0d_cfg_err", k), 32'(g_err), 32'(tbl[k].ee));
      chk($sformatf("vec%0d_latency", k), 32'(g_lat), 32'(tbl[k].el));
    end

    // Reset during AREF: immediate abort, no done pulse, then a clean restart.
    full_seq = 1'b1; burst_len = 3'b011; burst_type = 1'b0; cas_lat = 3'b010; wr_single = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (command == 4'd4) found = 1'b1;
      else @(negedge clk);
    end
    chk("aref_reached", 32'(found), 32'h1);
    #1 n_rst = 1'b0;
    #1;
    chk("midop_reset_cmd_busy", 32'({busy, command}), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("midop_no_done[%0d]", c), 32'({done, busy}), 32'h0);
    end
    n_rst = 1'b1;
    @(negedge clk);
    run_seq(1'b0, 3'b011, 1'b0, 3'b010, 1'b0, -1, g_addr, g_err, g_lat);
    chk("after_reset_addr", 32'(g_addr), 32'h023);
    chk("after_reset_latency", 32'(g_lat), 32'd3);

    // Randomized sequences, with random ignored start pulses and config churn.
    for (int r = 0; r < 30; r++) begin
      logic       rf, rbt, rws;
      logic [2:0] rbl, rcl;
      rf  = 1'($urandom);
      rbl = 3'($urandom);
      rbt = 1'($urandom);
      rcl = 3'($urandom);
      rws = 1'($urandom);
      run_seq(rf, rbl, rbt, rcl, rws, int'($urandom_range(0, 25)), g_addr, g_err, g_lat);
      chk($sformatf("rand%0d_latency", r), 32'(g_lat),
          32'(rf ? (T_RP + N_REF * T_RFC + T_MRD + 1) : (T_MRD + 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scg_mrs_seq.md
Name: scg_mrs_seq

Overview:
- Parametrised mode-register command sequence generator for the SDRAM controller's command path.
- Issues either a bare MODE REGISTER SET, or a full init sequence: PRECHARGE ALL, N_REF AUTO REFRESH, then MRS.
- Drives the command and address buses through all required tRP/tRFC/tMRD NOP gaps.
- The mode word is built from configuration inputs latched at start and validated; illegal fields are substituted and flagged.

Parameters:
- ADDR_W, 12, SDRAM address bus width; minimum 11.
- T_RP, 3, PRECHARGE-to-next-command spacing in clk cycles; minimum 1.
- T_RFC, 7, AUTO REFRESH-to-next-command spacing in cycles; minimum 1.
- T_MRD, 2, MRS-to-done spacing in cycles; minimum 1.
- N_REF, 2, number of AUTO REFRESH commands in full mode; 0 skips refresh.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- full_seq  in  1  sampled with start; 1 = PALL + refresh + MRS, 0 = MRS only.
- burst_len  in  3  BL code: 000=1, 001=2, 010=4, 011=8, 111=page.
- burst_type  in  1  0 sequential, 1 interleaved.
- cas_lat  in  3  CAS latency code; legal values 010 and 011.
- wr_single  in  1  write burst mode bit: 1 = single-location writes.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse at sequence end.
- cfg_err  out  1  valid with done; 1 if any field was substituted.
- command  out  4  command code: 0 NOP, 8 MRS, 2 PRECHARGE ALL, 4 AUTO REFRESH.
- addr  out  ADDR_W  address bus.

Behaviour:
- Reset: n_rst is asynchronous, active-low; clock is clk. Reset forces IDLE, and busy, done, cfg_err, command and addr all go to 0. Reset mid-sequence aborts immediately with no completion pulse.
- Latching: on start in IDLE, latch full_seq and all config fields; later input changes have no effect.
- Validation at latch:
  - burst_len 100, 101 or 110 → 011 used, error recorded.
  - cas_lat other than 010/011 → 011 used, error recorded.
- Mode word: [2:0] BL, [3] burst_type, [6:4] CAS, [8:7] 00, [9] wr_single, bits above 9 are 0.
- States: IDLE, PALL, WAIT_RP, AREF, WAIT_RFC, MRS, WAIT_MRD, DONE.
- Transitions:
  - IDLE: start with full_seq=1 → PALL; start with full_seq=0 → MRS.
  - PALL (1 cycle, command=2, addr[10]=1, other bits 0) → WAIT_RP for T_RP-1 cycles. If T_RP=1, skip WAIT_RP.
  - After WAIT_RP: if N_REF>0 → AREF, else → MRS.
  - AREF (1 cycle, command=4) → WAIT_RFC for T_RFC-1 cycles. Then → AREF again until N_REF refreshes are issued, otherwise → MRS.
  - MRS (1 cycle, command=8, addr=mode word) → WAIT_MRD for T_MRD-1 cycles → DONE.
  - DONE (1 cycle): done=1, cfg_err=latched error, command=0 → IDLE.
- Outputs outside command cycles: command=0 and addr=0 in all wait states and in IDLE.
- Handshake:
  - start while busy is ignored; DONE counts as busy.
  - start in the first IDLE cycle after DONE is accepted.
- Latency from start edge to done:
  - MRS-only: T_MRD+1 cycles.
  - Full: T_RP + N_REF·T_RFC + T_MRD + 1 cycles.
- Counters:
  - Shared wait counter, width $clog2(max(T_RP,T_RFC,T_MRD)+1).
  - Refresh counter, width $clog2(N_REF+1).
  - Both load on state entry and do not wrap.
- Outputs are registered from state: command/addr are valid for the whole cycle in which the state is held.

Test Plan:
- Reset: hold n_rst=0 with start=1 → all outputs 0; release → IDLE, busy=0.
- MRS-only (defaults), BL=011, type=0, CAS=010, wr_single=0 → one cycle command=8, addr=12'h023; one NOP; done=1, cfg_err=0. done occurs 3 cycles after start.
- Full sequence (defaults) → command 2 with addr=12'h400; 2 NOPs; command 4 + 6 NOPs, twice; command 8; 1 NOP; done. Total 20 cycles.
- Illegal config: BL=101, CAS=111 → MRS addr=12'h033; cfg_err=1 with done.
- Start during busy: pulse start mid-WAIT_RFC with new config → no restart, original addr word used; start on the cycle after DONE → new sequence begins.
- Reset mid-op: assert n_rst=0 during AREF → command=0 and busy=0 at once; no done pulse; a new start afterwards runs normally.
